// File: rtl/datapath_control_unit.sv
// Hardwired Moore sequencer for the DataPath: fetch, decode and execute strobes plus memory handshake.
// Optional build macro SINGLE_STEP_EN: hold in T0 until a step pulse, then run one instruction.
module datapath_control_unit #(
    parameter int         MEM_WAIT_MAX = 16,
    parameter int         CNT_W        = 32,
    parameter logic [4:0] OP_ADD       = 5'b00011
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      IR,
    input  logic             mem_ready,
    input  logic             step,
    output logic [15:0]      ctrl,
    output logic [2:0]       reg_sel,
    output logic [4:0]       alu_op,
    output logic             run,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4, S_T4 = 4'd5,
        S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9, S_TRAP = 4'd10
    } state_t;

    localparam int WCW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_WAIT_MAX - 1);

    localparam logic [15:0] PCOUT  = 16'h0001, PCIN   = 16'h0002, INCPC  = 16'h0004, MARIN = 16'h0008;
    localparam logic [15:0] MDRIN  = 16'h0010, MDROUT = 16'h0020, READ   = 16'h0040, WRITE = 16'h0080;
    localparam logic [15:0] IRIN   = 16'h0100, YIN    = 16'h0200, ZIN    = 16'h0400, ZLOOUT = 16'h0800;
    localparam logic [15:0] COUT   = 16'h1000, RIN    = 16'h2000, ROUT   = 16'h4000, BAOUT = 16'h8000;
    localparam logic [2:0]  GRA = 3'b100, GRB = 3'b010, GRC = 3'b001;
    localparam logic [4:0]  OPC_LD = 5'd0, OPC_ST = 5'd2, OPC_NOP = 5'd26, OPC_HALT = 5'd27;

    function automatic logic op_is_r(input logic [4:0] op);
        return (op >= 5'd3) && (op <= 5'd11);
    endfunction

    function automatic logic op_is_i(input logic [4:0] op);
        return (op >= 5'd12) && (op <= 5'd14);
    endfunction

    function automatic logic op_is_mem(input logic [4:0] op);
        return op <= 5'd2;
    endfunction

    function automatic logic op_is_ldst(input logic [4:0] op);
        return (op == OPC_LD) || (op == OPC_ST);
    endfunction

    // Strobe pattern of a state, packed as {alu_op, reg_sel, ctrl}.
    function automatic logic [23:0] decode(input state_t s, input logic [4:0] op, input logic armed);
        logic [15:0] c;
        logic [2:0]  g;
        logic [4:0]  a;
        c = 16'h0000;
        g = 3'b000;
        a = 5'b00000;
        case (s)
            S_T0: begin
                if (armed) c = PCOUT | MARIN | INCPC | ZIN;
                else       c = 16'h0000;
            end
            S_T1: c = ZLOOUT | PCIN | READ | MDRIN;
            S_T2: c = MDROUT | IRIN;
            S_T3: begin
                g = GRB;
                c = YIN | (op_is_mem(op) ? BAOUT : ROUT);
            end
            S_T4: begin
                if (op_is_r(op)) begin
                    g = GRC; c = ROUT | ZIN; a = op;
                end else if (op_is_i(op)) begin
                    c = COUT | ZIN; a = op;
                end else begin
                    c = COUT | ZIN; a = OP_ADD;
                end
            end
            S_T5: begin
                if (op_is_ldst(op)) begin
                    c = ZLOOUT | MARIN;
                end else begin
                    c = ZLOOUT | RIN; g = GRA;
                end
            end
            S_T6: begin
                if (op == OPC_LD) begin
                    c = READ | MDRIN;
                end else begin
                    c = ROUT | MDRIN; g = GRA;
                end
            end
            S_T7: begin
                if (op == OPC_LD) begin
                    c = MDROUT | RIN; g = GRA;
                end else begin
                    c = WRITE;
                end
            end
            default: c = 16'h0000;
        endcase
        return {a, g, c};
    endfunction

    state_t             state_r, next_state_s;
    logic [WCW-1:0]     wait_cnt_r, wait_cnt_next_s;
    logic [1:0]         fault_r, fault_next_s;
    logic [CNT_W-1:0]   count_r;
    logic [15:0]        ctrl_r;
    logic [2:0]         reg_sel_r;
    logic [4:0]         alu_r;
    logic               run_r, retire_s, wait_s, armed_s, armed_next_s, unused_s;
    logic [4:0]         op_s;

    assign op_s = IR[31:27];

`ifdef SINGLE_STEP_EN
    logic armed_r;
    assign armed_s      = armed_r;
    assign armed_next_s = (state_r == S_T0) && (next_state_s == S_T0) && step;
    assign unused_s     = ^IR[26:0];
`else
    assign armed_s      = 1'b1;
    assign armed_next_s = 1'b1;
    assign unused_s     = ^{step, IR[26:0]};
`endif

    assign wait_s = (state_r == S_T1) || ((state_r == S_T6) && (op_s == OPC_LD))
                  || ((state_r == S_T7) && (op_s == OPC_ST));

    // Next-state, retire and fault decision; wait states override the nominal transition.
    always_comb begin
        next_state_s    = state_r;
        wait_cnt_next_s = '0;
        fault_next_s    = fault_r;
        retire_s        = 1'b0;
        case (state_r)
            S_RST: next_state_s = S_T0;
            S_T0: begin
                if (armed_s) next_state_s = S_T1;
                else         next_state_s = S_T0;
            end
            S_T1: next_state_s = S_T2;
            S_T2: begin
                if (op_is_r(op_s) || op_is_i(op_s) || op_is_mem(op_s)) begin
                    next_state_s = S_T3;
                end else if (op_s == OPC_NOP) begin
                    next_state_s = S_T0; retire_s = 1'b1;
                end else if (op_s == OPC_HALT) begin
                    next_state_s = S_HALT; retire_s = 1'b1;
                end else begin
                    next_state_s = S_TRAP; fault_next_s = 2'b01;
                end
            end
            S_T3: next_state_s = S_T4;
            S_T4: next_state_s = S_T5;
            S_T5: begin
                if (op_is_ldst(op_s)) begin
                    next_state_s = S_T6;
                end else begin
                    next_state_s = S_T0; retire_s = 1'b1;
                end
            end
            S_T6: next_state_s = S_T7;
            S_T7: begin
                next_state_s = S_T0; retire_s = 1'b1;
            end
            S_HALT: next_state_s = S_HALT;
            S_TRAP: next_state_s = S_TRAP;
            default: next_state_s = S_RST;
        endcase
        if (wait_s && !mem_ready) begin
            retire_s = 1'b0;
            if (wait_cnt_r == WAIT_LAST) begin
                next_state_s = S_TRAP; fault_next_s = 2'b10;
            end else begin
                next_state_s    = state_r;
                wait_cnt_next_s = wait_cnt_r + WCW'(1);
            end
        end else begin
            wait_cnt_next_s = '0;
        end
    end

    // State, counters and registered strobes for the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= S_RST;
            wait_cnt_r <= '0;
            fault_r    <= 2'b00;
            count_r    <= '0;
            ctrl_r     <= 16'h0000;
            reg_sel_r  <= 3'b000;
            alu_r      <= 5'b00000;
            run_r      <= 1'b0;
`ifdef SINGLE_STEP_EN
            armed_r    <= 1'b0;
`endif
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_cnt_next_s;
            fault_r    <= fault_next_s;
            count_r    <= retire_s ? count_r + CNT_W'(1) : count_r;
            {alu_r, reg_sel_r, ctrl_r} <= decode(next_state_s, op_s, armed_next_s);
            run_r      <= !((next_state_s == S_RST) || (next_state_s == S_HALT) || (next_state_s == S_TRAP));
`ifdef SINGLE_STEP_EN
            armed_r    <= armed_next_s;
`endif
        end
    end

    // PCin must only fire in the T1 cycle where memory actually completes.
    assign ctrl        = {ctrl_r[15:2], ctrl_r[1] & mem_ready, ctrl_r[0]};
    assign reg_sel     = reg_sel_r;
    assign alu_op      = alu_r;
    assign run         = run_r;
    assign fault_code  = fault_r;
    assign instr_count = count_r;
endmodule

// File: tb/tb_datapath_control_unit.sv
// Directed scoreboard bench for datapath_control_unit: add, ld, st, nop, halt, traps and reset abort.
module tb_datapath_control_unit;
    logic        clock = 1'b0;
    logic        reset, mem_ready, step;
    logic [31:0] IR;
    logic [15:0] ctrl;
    logic [2:0]  reg_sel;
    logic [4:0]  alu_op;
    logic        run;
    logic [1:0]  fault_code;
    logic [31:0] instr_count;

    localparam logic [31:0] I_ADD = 32'h28918000, I_LD = 32'h01000065, I_ST = 32'h11800010;
    localparam logic [31:0] I_NOP = 32'hD0000000, I_HALT = 32'hD8000000, I_ILL = 32'h80000000;
    localparam logic [15:0] C_T0 = 16'h040D, C_T1 = 16'h0852, C_T1W = 16'h0850, C_T2 = 16'h0120;
    localparam logic [15:0] C_R3 = 16'h4200, C_R4 = 16'h4400, C_R5 = 16'h2800;
    localparam logic [15:0] C_M3 = 16'h8200, C_M4 = 16'h1400, C_M5 = 16'h0808;
    localparam logic [15:0] C_LD6 = 16'h0050, C_LD7 = 16'h2020, C_ST6 = 16'h4010, C_ST7 = 16'h0080;

    int tests_run = 0;
    int tests_failed = 0;
    string       tag_q[$];
    logic [58:0] exp_q[$];

    always #5 clock = ~clock;

    datapath_control_unit dut (
        .clock(clock), .reset(reset), .IR(IR), .mem_ready(mem_ready), .step(step),
        .ctrl(ctrl), .reg_sel(reg_sel), .alu_op(alu_op), .run(run),
        .fault_code(fault_code), .instr_count(instr_count)
    );

    task automatic check_front();
        string       t;
        logic [58:0] e, obs;
        t   = tag_q.pop_front();
        e   = exp_q.pop_front();
        obs = {ctrl, reg_sel, alu_op, run, fault_code, instr_count};
        tests_run++;
        assert (obs === e) else begin
            tests_failed++;
            $error("FAIL %s observed {ctrl,rs,alu,run,fault,cnt}=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic exp_cyc(input string t, input logic [15:0] c, input logic [2:0] rs,
                           input logic [4:0] a, input logic r, input logic [1:0] f, input logic [31:0] n);
        tag_q.push_back(t);
        exp_q.push_back({c, rs, a, r, f, n});
        @(posedge clock);
        #1;
        check_front();
    endtask

    task automatic fetch(input string t, input logic [31:0] n);
        exp_cyc({t, "_t1"}, C_T1, 3'b000, 5'd0, 1'b1, 2'b00, n);
        exp_cyc({t, "_t2"}, C_T2, 3'b000, 5'd0, 1'b1, 2'b00, n);
    endtask

    task automatic add_exec(input logic [31:0] n);
        exp_cyc("add_t3", C_R3, 3'b010, 5'd0, 1'b1, 2'b00, n);
        exp_cyc("add_t4", C_R4, 3'b001, 5'b00101, 1'b1, 2'b00, n);
        exp_cyc("add_t5", C_R5, 3'b100, 5'd0, 1'b1, 2'b00, n);
        exp_cyc("add_t0", C_T0, 3'b000, 5'd0, 1'b1, 2'b00, n + 32'd1);
    endtask

    task automatic addr_exec(input string t, input logic [31:0] n);
        exp_cyc({t, "_t3"}, C_M3, 3'b010, 5'd0, 1'b1, 2'b00, n);
        exp_cyc({t, "_t4"}, C_M4, 3'b000, 5'b00011, 1'b1, 2'b00, n);
        exp_cyc({t, "_t5"}, C_M5, 3'b000, 5'd0, 1'b1, 2'b00, n);
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; step = 1'b0; IR = I_ADD;
        repeat (2) @(posedge clock);
        #1;
        exp_cyc("reset", 16'h0, 3'b000, 5'd0, 1'b0, 2'b00, 32'd0);
        reset = 1'b0;
        exp_cyc("rel_t0", C_T0, 3'b000, 5'd0, 1'b1, 2'b00, 32'd0);
        fetch("add", 32'd0);
        add_exec(32'd0);

        IR = I_LD;
        fetch("ld", 32'd1);
        addr_exec("ld", 32'd1);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_cyc("ld_t6_hold", C_LD6, 3'b000, 5'd0, 1'b1, 2'b00, 32'd1);
        mem_ready = 1'b1;
        exp_cyc("ld_t7", C_LD7, 3'b100, 5'd0, 1'b1, 2'b00, 32'd1);
        exp_cyc("ld_t0", C_T0, 3'b000, 5'd0, 1'b1, 2'b00, 32'd2);

        IR = I_ST;
        fetch("st", 32'd2);
        addr_exec("st", 32'd2);
        mem_ready = 1'b0;
        exp_cyc("st_t6", C_ST6, 3'b100, 5'd0, 1'b1, 2'b00, 32'd2);
        exp_cyc("st_t7", C_ST7, 3'b000, 5'd0, 1'b1, 2'b00, 32'd2);
        exp_cyc("st_t7_hold", C_ST7, 3'b000, 5'd0, 1'b1, 2'b00, 32'd2);
        mem_ready = 1'b1;
        exp_cyc("st_t0", C_T0, 3'b000, 5'd0, 1'b1, 2'b00, 32'd3);

        IR = I_NOP;
        fetch("nop", 32'd3);
        exp_cyc("nop_t0", C_T0, 3'b000, 5'd0, 1'b1, 2'b00, 32'd4);

        IR = I_HALT;
        fetch("halt", 32'd4);
        for (int i = 0; i < 20; i++) exp_cyc("halt_hold", 16'h0, 3'b000, 5'd0, 1'b0, 2'b00, 32'd5);
        reset = 1'b1;
        exp_cyc("halt_reset", 16'h0, 3'b000, 5'd0, 1'b0, 2'b00, 32'd0);
        reset = 1'b0;
        exp_cyc("halt_rel_t0", C_T0, 3'b000, 5'd0, 1'b1, 2'b00, 32'd0);

        IR = I_ADD;
        fetch("add2", 32'd0);
        add_exec(32'd0);
        IR = I_ILL;
        fetch("ill", 32'd1);
        for (int i = 0; i < 3; i++) exp_cyc("trap_illegal", 16'h0, 3'b000, 5'd0, 1'b0, 2'b01, 32'd1);
        reset = 1'b1;
        exp_cyc("trap_reset", 16'h0, 3'b000, 5'd0, 1'b0, 2'b00, 32'd0);
        reset = 1'b0; mem_ready = 1'b0; IR = I_ADD;
        exp_cyc("to_t0", C_T0, 3'b000, 5'd0, 1'b1, 2'b00, 32'd0);
        for (int i = 0; i < 16; i++) exp_cyc("to_t1_wait", C_T1W, 3'b000, 5'd0, 1'b1, 2'b00, 32'd0);
        exp_cyc("to_trap", 16'h0, 3'b000, 5'd0, 1'b0, 2'b10, 32'd0);
        exp_cyc("to_trap_hold", 16'h0, 3'b000, 5'd0, 1'b0, 2'b10, 32'd0);

        reset = 1'b1;
        exp_cyc("to_reset", 16'h0, 3'b000, 5'd0, 1'b0, 2'b00, 32'd0);
        reset = 1'b0; mem_ready = 1'b1;
        exp_cyc("ab_t0", C_T0, 3'b000, 5'd0, 1'b1, 2'b00, 32'd0);
        fetch("ab1", 32'd0);
        add_exec(32'd0);
        fetch("ab2", 32'd1);
        exp_cyc("ab_t3", C_R3, 3'b010, 5'd0, 1'b1, 2'b00, 32'd1);
        exp_cyc("ab_t4", C_R4, 3'b001, 5'b00101, 1'b1, 2'b00, 32'd1);
        reset = 1'b1;
        exp_cyc("abort_reset", 16'h0, 3'b000, 5'd0, 1'b0, 2'b00, 32'd0);
        reset = 1'b0;
        exp_cyc("abort_rel_t0", C_T0, 3'b000, 5'd0, 1'b1, 2'b00, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/datapath_control_unit.md
Name: datapath_control_unit

Overview:
- Hardwired Moore control unit that sequences the existing DataPath through fetch, decode and execute.
- Replaces bench-driven strobes with generated ones.
- Decodes the IR word (opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15], C[18:0]).
- Asserts one control step per clock and handshakes with memory via mem_ready.

Parameters:
- MEM_WAIT_MAX, 16, max cycles a memory state waits for mem_ready before faulting (≥1)
- CNT_W, 32, width of retired-instruction counter
- OP_ADD, 5'b00011, alu_op code issued for address/ldi computation

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- IR  input  32  current instruction register contents
- mem_ready  input  1  memory has completed the current Read/Write this cycle
- step  input  1  single-step pulse (only with SINGLE_STEP_EN)
- ctrl  output  16  strobes: [0]PCout [1]PCin [2]IncPC [3]MARin [4]MDRin [5]MDRout [6]Read [7]Write [8]IRin [9]Yin [10]Zin [11]ZLOout [12]Cout [13]Rin [14]Rout [15]BAout
- reg_sel  output  3  {Gra,Grb,Grc} to select/encode logic
- alu_op  output  5  ALU operation code
- run  output  1  1 while executing
- fault_code  output  2  00 none, 01 illegal opcode, 10 memory timeout
- instr_count  output  CNT_W  retired instructions

Behaviour:
- Reset:
  - State=RST. ctrl, reg_sel, alu_op, run, fault_code and instr_count are all 0.
  - The first cycle after reset deassert enters T0. run=1 in every state except RST, HALT and TRAP.
  - Reset asserted in any state takes effect next edge, aborting the instruction.
- Outputs decode from the registered state and IR only. Each state lasts 1 cycle unless noted.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: ZLOout, PCin, Read, MDRin. Held while mem_ready=0; PCin pulses only in the cycle mem_ready=1.
  - T2: MDRout, IRin.
- Decode at T2 exit on IR[31:27]:
  - R-class: 00011–01011.
  - I-class: 01100–01110.
  - ld 00000, ldi 00001, st 00010, nop 11010, halt 11011.
  - Any other opcode goes to TRAP.
- R-class: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin, alu_op=opcode; T5 ZLOout,Gra,Rin.
- I-class: T3 Grb,Rout,Yin; T4 Cout,Zin, alu_op=opcode; T5 ZLOout,Gra,Rin.
- ldi: T3 Grb,BAout,Yin; T4 Cout,Zin, alu_op=OP_ADD; T5 ZLOout,Gra,Rin.
- ld:
  - T3/T4 same as ldi; T5 ZLOout,MARin.
  - T6 Read,MDRin, held until mem_ready.
  - T7 MDRout,Gra,Rin.
- st:
  - T3–T4 same as ldi; T5 ZLOout,MARin.
  - T6 Gra,Rout,MDRin (Read=0).
  - T7 Write, held until mem_ready.
- nop: T2 goes to T0.
- halt: T2 goes to HALT. In HALT, ctrl=0 and run=0 until reset.
- TRAP:
  - ctrl=0, run=0, fault_code latched, held until reset.
  - Entered on an illegal opcode (01).
  - Entered when any wait state (T1, ld T6, st T7) sees mem_ready=0 for MEM_WAIT_MAX consecutive cycles (10). The wait counter clears on state entry.
- mem_ready=1 on first cycle of a wait state means no stall. mem_ready is ignored outside wait states.
- alu_op=0 whenever not listed.
- Completion: instr_count increments by 1 on the final execute state of R, I, ldi, ld, st, nop, halt. It wraps modulo 2^CNT_W. A trapped instruction does not count.

Optional Feature:
- SINGLE_STEP_EN defined: the FSM stays in T0 with ctrl=0 until a cycle with step=1, then runs one full instruction and returns to wait in T0. run=1 throughout.
- SINGLE_STEP_EN undefined: step is ignored, tie-off allowed, and T0 issues immediately.

Test Plan:
- mem_ready=1, IR=0x28918000 (and R1,R2,R3) → T3 reg_sel=010 Rout Yin; T4 reg_sel=001 Zin alu_op=00101; T5 reg_sel=100 ZLOout Rin; T0 on cycle 7; instr_count=1.
- IR=0x01000065 (ld R2,0x65(R0)), mem_ready low 3 cycles in T6 → Read+MDRin held 4 cycles, then T7 reg_sel=100 Rin; T4 alu_op=00011, Cout.
- IR=0x11800010 (st R3,0x10(R0)) → T6 Gra Rout MDRin with Read=0; T7 Write held until mem_ready; instr_count+1.
- IR=0xD8000000 (halt) → after T2 run=0, ctrl=0 for 20 cycles; instr_count+1; reset → RST then T0.
- IR=0x80000000 → TRAP, fault_code=01, count unchanged. mem_ready=0 in T1 for 16 cycles → fault_code=10.
- reset asserted during T4 of an add → next cycle all outputs 0, instr_count=0; T0 one cycle after release.
